// File: rtl/blob_line_reader.sv
// Read-side sequencer for the BLOB line buffer: walks RAM port B for one line
// and presents the pixels on a valid/ready stream with start/end-of-line flags.
module blob_line_reader #(
    parameter int AW   = 14,
    parameter int DW   = 8,
    parameter int ROWW = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [AW-1:0]   base_addr,
    input  logic [AW-1:0]   line_len,
    output logic [AW-1:0]   rd_addr,
    input  logic [DW-1:0]   rd_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [DW-1:0]   m_data,
    output logic            m_sol,
    output logic            m_eol,
    output logic            busy,
    output logic            done,
    output logic [ROWW-1:0] line_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [AW:0] REM_ONE = (AW+1)'(1);

    state_t        state, state_next;
    logic [AW-1:0] ptr;
    logic [AW:0]   remaining;
    logic          first;
    logic          accept, load, launch, empty_req;

    assign accept    = m_valid && m_ready;
    assign load      = (state == RUN) && (|remaining) && (!m_valid || m_ready);
    assign launch    = (state == IDLE) && start && (|line_len);
    assign empty_req = (state == IDLE) && start && !(|line_len);
    assign rd_addr   = ptr;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (launch) state_next = RUN;
            RUN:     if (load && remaining == REM_ONE) state_next = DRAIN;
            DRAIN:   if (accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: load overlaps the handshake of the previous beat, so only the
    // final (m_eol) beat needs a separate DRAIN acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            remaining <= '0;
            first     <= 1'b0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_sol     <= 1'b0;
            m_eol     <= 1'b0;
            done      <= 1'b0;
            line_cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (launch) begin
                ptr       <= base_addr;
                remaining <= {1'b0, line_len};
                first     <= 1'b1;
            end
            if (empty_req) done <= 1'b1;
            if (load) begin
                m_data    <= rd_data;
                m_sol     <= first;
                m_eol     <= (remaining == REM_ONE);
                m_valid   <= 1'b1;
                ptr       <= ptr + 1'b1;
                remaining <= remaining - 1'b1;
                first     <= 1'b0;
            end else if (state == DRAIN && accept) begin
                m_valid  <= 1'b0;
                m_sol    <= 1'b0;
                m_eol    <= 1'b0;
                done     <= 1'b1;
                line_cnt <= line_cnt + 1'b1;
            end
        end
    end

endmodule
